// File: rtl/test_port_driver.sv
// Test-port write stream generator: BEGIN_SYM, NUM_TERMS ascending Fibonacci words, the same words descending, END_SYM.
// Latency: start sampled at a clock edge drives the first write (BEGIN_SYM) in the cycle that edge begins; all outputs registered.
// Backpressure: stall high on the last hold cycle of a write stretches that write; stall is ignored in gaps, idle and done.
module test_port_driver #(
    parameter logic [29:0] TEST_PORT = 30'h40,
    parameter logic [31:0] BEGIN_SYM = 32'h00000932,
    parameter logic [31:0] END_SYM   = 32'h00000D5D,
    parameter int unsigned NUM_TERMS = 16,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [7:0]  wr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEG,
        S_ASC,
        S_DESC,
        S_ENDW,
        S_DONE
    } state_t;

    // Phase counters count up to the last cycle of the phase and hold there.
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [5:0]  TERM_LAST = 6'(NUM_TERMS - 1);

    state_t      state_q, state_d;
    logic        wr_ph_q, wr_ph_d;      // 1 = write phase, 0 = gap phase
    logic [15:0] cyc_q,   cyc_d;        // cycle index inside the current phase
    logic [5:0]  idx_q,   idx_d;        // term index inside ASC / DESC
    logic [31:0] a_q,     a_d;          // current Fibonacci term (the word written)
    logic [31:0] b_q,     b_d;          // neighbouring term used to step up or down
    logic [7:0]  cnt_q,   cnt_d;        // completed writes since last start

    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wen_q,  wen_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Sequencer and Fibonacci datapath state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wr_ph_q <= 1'b0;
            cyc_q   <= '0;
            idx_q   <= '0;
            a_q     <= 32'd0;
            b_q     <= 32'd1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_ph_q <= wr_ph_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: walk write/gap phases, step the Fibonacci pair at the end of each write
    always_comb begin
        state_d = state_q;
        wr_ph_d = wr_ph_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_BEG;
                    wr_ph_d = 1'b1;
                    cyc_d   = '0;
                    idx_d   = '0;
                    a_d     = 32'd0;
                    b_d     = 32'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (wr_ph_q) begin
                    if (cyc_q != HOLD_LAST) begin
                        cyc_d = cyc_q + 16'd1;
                    end else if (!stall) begin
                        wr_ph_d = 1'b0;
                        cyc_d   = '0;
                        cnt_d   = cnt_q + 8'd1;
                        // The last term of each direction is not stepped past, so
                        // DESC begins by repeating the final ASC word.
                        if (idx_q != TERM_LAST) begin
                            if (state_q == S_ASC) begin
                                a_d = b_q;
                                b_d = a_q + b_q;
                            end else if (state_q == S_DESC) begin
                                a_d = b_q - a_q;
                                b_d = a_q;
                            end
                        end
                    end
                end else if (cyc_q != GAP_LAST) begin
                    cyc_d = cyc_q + 16'd1;
                end else begin
                    wr_ph_d = 1'b1;
                    cyc_d   = '0;
                    case (state_q)
                        S_BEG: begin
                            state_d = S_ASC;
                            idx_d   = '0;
                        end
                        S_ASC, S_DESC: begin
                            if (idx_q != TERM_LAST) begin
                                idx_d = idx_q + 6'd1;
                            end else begin
                                idx_d   = '0;
                                state_d = (state_q == S_ASC) ? S_DESC : S_ENDW;
                            end
                        end
                        S_ENDW: begin
                            state_d = S_DONE;
                            wr_ph_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it
    always_comb begin
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        wen_d  = busy_d && wr_ph_d;
        done_d = (state_d == S_DONE);
        addr_d = '0;
        data_d = '0;
        if (wen_d) begin
            addr_d = TEST_PORT;
            case (state_d)
                S_BEG:   data_d = BEGIN_SYM;
                S_ENDW:  data_d = END_SYM;
                default: data_d = a_d;
            endcase
        end
    end

    // Output registers: nothing combinational reaches the ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            wen_q  <= wen_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign addr   = addr_q;
    assign data   = data_q;
    assign wen    = wen_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_cnt = cnt_q;

endmodule
